// File: rtl/if_id_skid_reg.sv
// if_id_skid_reg: fetch -> decode pipeline boundary with a 2-entry skid buffer.
//
// Each fetched {pc, instr} beat is captured through a valid/ready handshake and
// presented to decode one cycle later. Nothing is forwarded combinationally from
// if_* to id_*. A second (skid) entry absorbs the beat that is already in flight
// when decode stalls, so if_ready can be a registered output.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   if_valid        fetch beat valid
//   if_ready        buffer can accept a beat (registered, 0 only while FULL)
//   if_pc/if_instr  fetched beat payload
//   flush           drop all held and incoming beats at the next edge
//   id_valid        decode beat valid
//   id_ready        decode accepts the beat (0 = stall)
//   id_pc           pc of the presented beat (holds last value when idle)
//   id_pc_plus4     id_pc + 4, wrapping
//   id_instr        presented instruction, NOP_INSTR when id_valid = 0
//   id_misaligned   id_pc[1:0] != 0, forced to 0 when id_valid = 0
//
// Optional build macro IFID_PERF_CNT_EN adds saturating counters:
//   stall_cycles    cycles with id_valid & !id_ready
//   bubble_cycles   cycles with !id_valid
//   flush_count     cycles with flush asserted

module if_id_skid_reg #(
   parameter int unsigned         ADDR_W    = 32,
   parameter int unsigned         INSTR_W   = 32,
   parameter logic [INSTR_W-1:0]  NOP_INSTR = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               if_valid,
   output logic               if_ready,
   input  logic [ADDR_W-1:0]  if_pc,
   input  logic [INSTR_W-1:0] if_instr,
   input  logic               flush,
   output logic               id_valid,
   input  logic               id_ready,
   output logic [ADDR_W-1:0]  id_pc,
   output logic [ADDR_W-1:0]  id_pc_plus4,
   output logic [INSTR_W-1:0] id_instr,
   output logic               id_misaligned
`ifdef IFID_PERF_CNT_EN
  ,output logic [31:0]        stall_cycles,
   output logic [31:0]        bubble_cycles,
   output logic [15:0]        flush_count
`endif
);

   typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

   state_e               state_q, state_d;
   logic [ADDR_W-1:0]    main_pc_q, main_pc_d;
   logic [INSTR_W-1:0]   main_instr_q, main_instr_d;
   logic [ADDR_W-1:0]    skid_pc_q, skid_pc_d;
   logic [INSTR_W-1:0]   skid_instr_q, skid_instr_d;
   logic                 if_ready_q;
   logic                 accept, retire;

   assign id_valid = (state_q != StEmpty);
   assign if_ready = if_ready_q;
   assign accept   = if_valid & if_ready_q;
   assign retire   = id_valid & id_ready;

   always_comb begin
      state_d      = state_q;
      main_pc_d    = main_pc_q;
      main_instr_d = main_instr_q;
      skid_pc_d    = skid_pc_q;
      skid_instr_d = skid_instr_q;
      if (flush) begin
         // main_pc is left alone so id_pc keeps its last value while idle
         state_d = StEmpty;
      end else begin
         case (state_q)
            StEmpty: begin
               if (accept) begin
                  state_d      = StOne;
                  main_pc_d    = if_pc;
                  main_instr_d = if_instr;
               end
            end
            StOne: begin
               if (accept && retire) begin
                  main_pc_d    = if_pc;
                  main_instr_d = if_instr;
               end else if (accept) begin
                  state_d      = StFull;
                  skid_pc_d    = if_pc;
                  skid_instr_d = if_instr;
               end else if (retire) begin
                  state_d = StEmpty;
               end
            end
            StFull: begin
               if (retire) begin
                  state_d      = StOne;
                  main_pc_d    = skid_pc_q;
                  main_instr_d = skid_instr_q;
               end
            end
            default: state_d = StEmpty;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StEmpty;
         main_pc_q    <= '0;
         main_instr_q <= NOP_INSTR;
         skid_pc_q    <= '0;
         skid_instr_q <= NOP_INSTR;
         if_ready_q   <= 1'b1;
      end else begin
         state_q      <= state_d;
         main_pc_q    <= main_pc_d;
         main_instr_q <= main_instr_d;
         skid_pc_q    <= skid_pc_d;
         skid_instr_q <= skid_instr_d;
         if_ready_q   <= (state_d != StFull);
      end
   end

   assign id_pc         = main_pc_q;
   assign id_pc_plus4   = main_pc_q + ADDR_W'(4);
   assign id_instr      = id_valid ? main_instr_q : NOP_INSTR;
   assign id_misaligned = id_valid & (main_pc_q[1:0] != 2'b00);

`ifdef IFID_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles  <= '0;
         bubble_cycles <= '0;
         flush_count   <= '0;
      end else begin
         if (id_valid && !id_ready && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
         end
         if (!id_valid && (bubble_cycles != '1)) begin
            bubble_cycles <= bubble_cycles + 32'd1;
         end
         if (flush && (flush_count != '1)) begin
            flush_count <= flush_count + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Self-checking bench for if_id_skid_reg: directed vector table, mid-cycle reset,
// then randomized traffic checked against a queue-based reference model.

module tb_if_id_skid_reg;

   logic        clk;
   logic        rst;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        flush;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;
   logic [31:0] id_instr;
   logic        id_misaligned;
`ifdef IFID_PERF_CNT_EN
   logic [31:0] stall_cycles;
   logic [31:0] bubble_cycles;
   logic [15:0] flush_count;
`endif

   if_id_skid_reg dut (
      .clk          (clk),
      .rst          (rst),
      .if_valid     (if_valid),
      .if_ready     (if_ready),
      .if_pc        (if_pc),
      .if_instr     (if_instr),
      .flush        (flush),
      .id_valid     (id_valid),
      .id_ready     (id_ready),
      .id_pc        (id_pc),
      .id_pc_plus4  (id_pc_plus4),
      .id_instr     (id_instr),
      .id_misaligned(id_misaligned)
`ifdef IFID_PERF_CNT_EN
     ,.stall_cycles (stall_cycles),
      .bubble_cycles(bubble_cycles),
      .flush_count  (flush_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: the buffer is a FIFO of at most two beats; head is presented.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } beat_t;

   beat_t       mq[$];
   logic [31:0] m_last_pc;
   logic        m_ifr;
   int          m_stall, m_bubble, m_flush;

   task automatic model_reset();
      mq.delete();
      m_last_pc = 32'h0;
      m_ifr     = 1'b1;
      m_stall   = 0;
      m_bubble  = 0;
      m_flush   = 0;
   endtask

   task automatic model_update();
      bit    acc, ret;
      beat_t b;
      acc = if_valid && m_ifr;
      ret = (mq.size() > 0) && id_ready;
      if (mq.size() > 0 && !id_ready) m_stall++;
      if (mq.size() == 0) m_bubble++;
      if (flush) m_flush++;
      if (flush) begin
         mq.delete();
      end else begin
         if (ret) void'(mq.pop_front());
         if (acc) begin
            b.pc    = if_pc;
            b.instr = if_instr;
            mq.push_back(b);
         end
      end
      if (mq.size() > 0) m_last_pc = mq[0].pc;
      m_ifr = (mq.size() < 2);
   endtask

   task automatic check_model();
      logic        v;
      logic [31:0] pc;
      v  = (mq.size() != 0);
      pc = v ? mq[0].pc : m_last_pc;
      chk("m_id_valid", {31'b0, id_valid}, {31'b0, v});
      chk("m_if_ready", {31'b0, if_ready}, {31'b0, m_ifr});
      chk("m_id_pc", id_pc, pc);
      chk("m_id_pc_plus4", id_pc_plus4, pc + 32'd4);
      chk("m_id_instr", id_instr, v ? mq[0].instr : 32'h0);
      chk("m_id_misaligned", {31'b0, id_misaligned}, {31'b0, v && (pc[1:0] != 2'b00)});
   endtask

   task automatic tick();
      model_update();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        iv;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        fl;
      logic        idr;
      logic        e_v;
      logic        e_r;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
      logic        e_mis;
   } vec_t;

   vec_t tbl[23];

   function automatic vec_t mk(logic iv, logic [31:0] pc, logic [31:0] instr, logic fl,
                               logic idr, logic e_v, logic e_r, logic [31:0] e_pc,
                               logic [31:0] e_instr, logic e_mis);
      vec_t t;
      t.iv = iv; t.pc = pc; t.instr = instr; t.fl = fl; t.idr = idr;
      t.e_v = e_v; t.e_r = e_r; t.e_pc = e_pc; t.e_instr = e_instr; t.e_mis = e_mis;
      return t;
   endfunction

   initial begin
      // Outputs listed are those seen during the row's cycle, before its edge.
      // streaming
      tbl[0]  = mk(1, 32'h100, 32'hA, 0, 1,  0, 1, 32'h0,   32'h0,  0);
      tbl[1]  = mk(1, 32'h104, 32'hB, 0, 1,  1, 1, 32'h100, 32'hA,  0);
      tbl[2]  = mk(1, 32'h108, 32'hC, 0, 1,  1, 1, 32'h104, 32'hB,  0);
      tbl[3]  = mk(0, 32'h0,   32'h0, 0, 1,  1, 1, 32'h108, 32'hC,  0);
      tbl[4]  = mk(0, 32'h0,   32'h0, 0, 1,  0, 1, 32'h108, 32'h0,  0);
      // stall fill
      tbl[5]  = mk(1, 32'h200, 32'h20, 0, 0, 0, 1, 32'h108, 32'h0,  0);
      tbl[6]  = mk(1, 32'h204, 32'h21, 0, 0, 1, 1, 32'h200, 32'h20, 0);
      tbl[7]  = mk(1, 32'h208, 32'h22, 0, 0, 1, 0, 32'h200, 32'h20, 0);
      tbl[8]  = mk(1, 32'h208, 32'h22, 0, 0, 1, 0, 32'h200, 32'h20, 0);
      tbl[9]  = mk(1, 32'h208, 32'h22, 0, 0, 1, 0, 32'h200, 32'h20, 0);
      tbl[10] = mk(1, 32'h208, 32'h22, 0, 1, 1, 0, 32'h200, 32'h20, 0);
      tbl[11] = mk(1, 32'h208, 32'h22, 0, 1, 1, 1, 32'h204, 32'h21, 0);
      tbl[12] = mk(0, 32'h0,   32'h0,  0, 1, 1, 1, 32'h208, 32'h22, 0);
      // flush while full
      tbl[13] = mk(1, 32'h300, 32'h30, 0, 0, 0, 1, 32'h208, 32'h0,  0);
      tbl[14] = mk(1, 32'h304, 32'h31, 0, 0, 1, 1, 32'h300, 32'h30, 0);
      tbl[15] = mk(1, 32'h308, 32'h32, 1, 0, 1, 0, 32'h300, 32'h30, 0);
      tbl[16] = mk(1, 32'h400, 32'h40, 0, 1, 0, 1, 32'h300, 32'h0,  0);
      tbl[17] = mk(0, 32'h0,   32'h0,  0, 1, 1, 1, 32'h400, 32'h40, 0);
      // boundaries: wrap of pc+4, misalignment
      tbl[18] = mk(1, 32'hFFFF_FFFC, 32'h50, 0, 1, 0, 1, 32'h400, 32'h0, 0);
      tbl[19] = mk(1, 32'h102, 32'h51, 0, 1, 1, 1, 32'hFFFF_FFFC, 32'h50, 0);
      tbl[20] = mk(1, 32'h104, 32'h52, 0, 1, 1, 1, 32'h102, 32'h51, 1);
      tbl[21] = mk(0, 32'h0,   32'h0,  0, 1, 1, 1, 32'h104, 32'h52, 0);
      tbl[22] = mk(0, 32'h0,   32'h0,  0, 1, 0, 1, 32'h104, 32'h0,  0);

      rst = 1'b1; if_valid = 1'b0; if_pc = '0; if_instr = '0; flush = 1'b0; id_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Load one beat, then hit reset mid-cycle while fetch is still offering.
      if_valid = 1'b1; if_pc = 32'h504; if_instr = 32'h77;
      tick();
      chk("pre_rst_id_valid", {31'b0, id_valid}, 32'd1);
      if_pc = 32'h508;
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
      chk("rst_if_ready", {31'b0, if_ready}, 32'd1);
      chk("rst_id_instr", id_instr, 32'h0);
      chk("rst_id_pc", id_pc, 32'h0);
      chk("rst_id_pc_plus4", id_pc_plus4, 32'h4);
      chk("rst_id_misaligned", {31'b0, id_misaligned}, 32'd0);
`ifdef IFID_PERF_CNT_EN
      chk("rst_stall_cycles", stall_cycles, 32'd0);
      chk("rst_bubble_cycles", bubble_cycles, 32'd0);
      chk("rst_flush_count", {16'b0, flush_count}, 32'd0);
`endif
      rst = 1'b0;
      if_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("idle_id_valid", {31'b0, id_valid}, 32'd0);
         chk("idle_if_ready", {31'b0, if_ready}, 32'd1);
         chk("idle_id_instr", id_instr, 32'h0);
         chk("idle_id_pc_plus4", id_pc_plus4, 32'h4);
         tick();
      end

      for (int i = 0; i < 23; i++) begin
         if_valid = tbl[i].iv; if_pc = tbl[i].pc; if_instr = tbl[i].instr;
         flush = tbl[i].fl; id_ready = tbl[i].idr;
         @(negedge clk);
         chk($sformatf("v%0d_id_valid", i), {31'b0, id_valid}, {31'b0, tbl[i].e_v});
         chk($sformatf("v%0d_if_ready", i), {31'b0, if_ready}, {31'b0, tbl[i].e_r});
         chk($sformatf("v%0d_id_pc", i), id_pc, tbl[i].e_pc);
         chk($sformatf("v%0d_id_pc_plus4", i), id_pc_plus4, tbl[i].e_pc + 32'd4);
         chk($sformatf("v%0d_id_instr", i), id_instr, tbl[i].e_instr);
         chk($sformatf("v%0d_id_misaligned", i), {31'b0, id_misaligned}, {31'b0, tbl[i].e_mis});
         check_model();
         tick();
      end

      for (int i = 0; i < 3000; i++) begin
         if_valid = ($urandom_range(0, 3) != 0);
         id_ready = ($urandom_range(0, 2) != 0);
         flush    = ($urandom_range(0, 19) == 0);
         if_pc    = $urandom;
         if_instr = $urandom;
         @(negedge clk);
         check_model();
         tick();
      end

      if_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
`ifdef IFID_PERF_CNT_EN
      chk("perf_stall_cycles", stall_cycles, m_stall);
      chk("perf_bubble_cycles", bubble_cycles, m_bubble);
      chk("perf_flush_count", {16'b0, flush_count}, m_flush);
`endif
      check_model();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
